ram_arb: RTL and testbench

RAM_ARB -- requirements
Module: ram_arb

---
 rtl/riscy_pkg.sv | 14 +
 rtl/rr_pick2.sv | 23 ++
 rtl/ram_arb.sv | 130 +++++++++++++
 tb/tb_ram_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscy_pkg.sv
// Shared types and default sizes for the RAM arbiter slice.
package riscy_pkg;

  localparam int unsigned DEF_ADR_SIZE = 5;
  localparam int unsigned DEF_DAT_SIZE = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone eligible request wins outright, a tie goes
// to the requester that was not served last.
module rr_pick2 (
  input  logic [1:0] REQ,
  input  logic       LAST,
  input  logic [1:0] EXCL,
  output logic [1:0] PICK
);

  logic [1:0] eligible;

  always_comb begin
    eligible = REQ & ~EXCL;
    PICK     = 2'b00;
    unique case (eligible)
      2'b01:   PICK = 2'b01;
      2'b10:   PICK = 2'b10;
      2'b11:   PICK = LAST ? 2'b01 : 2'b10;
      default: PICK = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arb.sv
// Two-requester arbiter for a single shared asynchronous RAM. Each access runs
// IDLE -> SETUP -> ACCESS -> DONE, with back-to-back hand-over from DONE.
module ram_arb
  import riscy_pkg::*;
#(
  parameter int unsigned ADR_SIZE = DEF_ADR_SIZE,
  parameter int unsigned DAT_SIZE = DEF_DAT_SIZE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            REQ,
  input  logic [1:0]            WE,
  input  logic [2*ADR_SIZE-1:0] ADR_IN,
  input  logic [2*DAT_SIZE-1:0] WD_IN,
  output logic [1:0]            GNT,
  output logic [1:0]            ACK,
  output logic [DAT_SIZE-1:0]   RD_DATA,
  output logic                  RAM_CS,
  output logic                  RAM_OE,
  output logic [ADR_SIZE-1:0]   RAM_ADR,
  output logic [DAT_SIZE-1:0]   RAM_WD,
  output logic                  RAM_WD_EN,
  input  logic [DAT_SIZE-1:0]   RAM_RD,
  output logic                  BUSY
);

  arb_state_e          state_q, state_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADR_SIZE-1:0] adr_q, adr_d;
  logic [DAT_SIZE-1:0] wd_q, wd_d;
  logic [DAT_SIZE-1:0] rd_q, rd_d;

  logic [1:0]          pick;
  logic [1:0]          excl;
  logic                sel_we;
  logic [ADR_SIZE-1:0] sel_adr;
  logic [DAT_SIZE-1:0] sel_wd;
  logic                ram_cycle;

  // In DONE the requester just served is masked so the other side gets the slot.
  assign excl = (state_q == StDone) ? gnt_q : 2'b00;

  rr_pick2 u_pick (
    .REQ  (REQ),
    .LAST (last_q),
    .EXCL (excl),
    .PICK (pick)
  );

  always_comb begin
    sel_we  = pick[1] ? WE[1] : WE[0];
    sel_adr = pick[1] ? ADR_IN[ADR_SIZE +: ADR_SIZE] : ADR_IN[0 +: ADR_SIZE];
    sel_wd  = pick[1] ? WD_IN[DAT_SIZE +: DAT_SIZE] : WD_IN[0 +: DAT_SIZE];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (pick != 2'b00) begin
          state_d = StSetup;
          gnt_d   = pick;
          we_d    = sel_we;
          adr_d   = sel_adr;
          wd_d    = sel_wd;
        end else begin
          state_d = StIdle;
          gnt_d   = 2'b00;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        state_d = StDone;
        last_d  = gnt_q[1];
        if (!we_q) begin
          rd_d = RAM_RD;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
    end
  end

  // Strobes decode straight from registered state so reset reaches them at once.
  always_comb begin
    ram_cycle = (state_q == StSetup) || (state_q == StAccess);
    BUSY      = (state_q != StIdle);
    GNT       = gnt_q;
    ACK       = (state_q == StDone) ? gnt_q : 2'b00;
    RAM_CS    = ~ram_cycle;
    RAM_OE    = ram_cycle & ~we_q;
    RAM_WD_EN = (state_q == StAccess) & we_q;
    RAM_ADR   = adr_q;
    RAM_WD    = wd_q;
    RD_DATA   = rd_q;
  end

endmodule

// File: tb/tb_ram_arb.sv
// Self-checking bench for ram_arb: behavioural RAM, expected-transaction
// scoreboard and per-scenario tasks.
module tb_ram_arb;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam logic [28:0] RESET_SNAP = {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 8'h00, 8'h00};

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [1:0]     REQ = 2'b00;
  logic [1:0]     WE = 2'b00;
  logic [2*AW-1:0] ADR_IN = '0;
  logic [2*DW-1:0] WD_IN = '0;
  logic [1:0]     GNT, ACK;
  logic [DW-1:0]  RD_DATA, RAM_WD, RAM_RD;
  logic           RAM_CS, RAM_OE, RAM_WD_EN, BUSY;
  logic [AW-1:0]  RAM_ADR;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic       we;
    logic [4:0] adr;
    logic [7:0] data;
  } txn_t;

  txn_t       sb[$];
  txn_t       mon_e;
  logic [7:0] mem [32] = '{default: 8'h00};
  logic [7:0] exp_mem [32] = '{default: 8'h00};

  ram_arb #(.ADR_SIZE(AW), .DAT_SIZE(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .WE        (WE),
    .ADR_IN    (ADR_IN),
    .WD_IN     (WD_IN),
    .GNT       (GNT),
    .ACK       (ACK),
    .RD_DATA   (RD_DATA),
    .RAM_CS    (RAM_CS),
    .RAM_OE    (RAM_OE),
    .RAM_ADR   (RAM_ADR),
    .RAM_WD    (RAM_WD),
    .RAM_WD_EN (RAM_WD_EN),
    .RAM_RD    (RAM_RD),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  // Asynchronous RAM on the shared bus: writes land on the edge ending ACCESS.
  assign RAM_RD = mem[RAM_ADR];
  always @(posedge CLK) begin
    if (!RAM_CS && RAM_WD_EN) mem[RAM_ADR] <= RAM_WD;
  end

  // Invariants every cycle, plus scoreboard pop on each ACK.
  always @(negedge CLK) begin
    checks++;
    if (GNT == 2'b11 || (RAM_WD_EN && RAM_OE) || (!RAM_CS && (!BUSY || ACK != 2'b00))) begin
      failures++;
      $display("FAIL invariant: GNT=%b WD_EN=%b OE=%b CS=%b BUSY=%b ACK=%b", GNT, RAM_WD_EN,
               RAM_OE, RAM_CS, BUSY, ACK);
    end
    if (ACK != 2'b00) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: ACK=%b with no transaction outstanding", ACK);
      end else begin
        mon_e = sb.pop_front();
        if (ACK !== (2'b01 << mon_e.idx) || (ACK & ~GNT) != 2'b00) begin
          failures++;
          $display("FAIL ack_target: ACK=%b GNT=%b expected requester %0d", ACK, GNT, mon_e.idx);
        end
        if (!mon_e.we) begin
          checks++;
          if (RD_DATA !== mon_e.data) begin
            failures++;
            $display("FAIL rd_data: got %h expected %h (adr %h)", RD_DATA, mon_e.data, mon_e.adr);
          end
        end
      end
    end
  end

  function automatic logic [28:0] snap();
    return {GNT, ACK, BUSY, RAM_CS, RAM_OE, RAM_WD_EN, RAM_ADR, RAM_WD, RD_DATA};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_port(input int idx, input logic we, input logic [4:0] adr,
                          input logic [7:0] wd);
    WE[idx]            = we;
    ADR_IN[idx*AW +: AW] = adr;
    WD_IN[idx*DW +: DW]  = wd;
  endtask

  task automatic push_txn(input int idx, input logic we, input logic [4:0] adr,
                          input logic [7:0] wd);
    txn_t e;
    e.idx = idx;
    e.we  = we;
    e.adr = adr;
    if (we) exp_mem[adr] = wd;
    e.data = we ? wd : exp_mem[adr];
    sb.push_back(e);
  endtask

  // One isolated transaction with latency and bus-phase checks.
  task automatic do_txn(input int idx, input logic we, input logic [4:0] adr,
                        input logic [7:0] wd, input bit drop_early, input string name);
    int n;
    bit got;
    set_port(idx, we, adr, wd);
    push_txn(idx, we, adr, wd);
    REQ[idx] = 1'b1;
    n   = 0;
    got = 0;
    while (!got && n < 10) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (GNT !== (2'b01 << idx) || RAM_CS !== 1'b0 || RAM_ADR !== adr || RAM_OE !== !we ||
            RAM_WD_EN !== 1'b0) begin
          failures++;
          $display("FAIL %s_setup: GNT=%b CS=%b ADR=%h OE=%b WD_EN=%b expected GNT=%b ADR=%h",
                   name, GNT, RAM_CS, RAM_ADR, RAM_OE, RAM_WD_EN, 2'b01 << idx, adr);
        end
        if (drop_early) REQ[idx] = 1'b0;
      end
      if (n == 2) begin
        checks++;
        if (RAM_CS !== 1'b0 || RAM_WD_EN !== we || RAM_OE !== !we || (we && RAM_WD !== wd)) begin
          failures++;
          $display("FAIL %s_access: CS=%b WD_EN=%b OE=%b WD=%h expected we=%b wd=%h", name,
                   RAM_CS, RAM_WD_EN, RAM_OE, RAM_WD, we, wd);
        end
      end
      if (ACK != 2'b00) got = 1;
    end
    checks++;
    if (!got || n != 3) begin
      failures++;
      $display("FAIL %s_latency: ack seen=%0d after %0d edges, expected after 3", name, got, n);
    end
    REQ[idx] = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0 || GNT !== 2'b00) begin
      failures++;
      $display("FAIL %s_idle: BUSY=%b GNT=%b expected 0 and 00", name, BUSY, GNT);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    REQ = 2'b00;
    repeat (2) tick();
    checks++;
    if (snap() !== RESET_SNAP) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", snap(), RESET_SNAP);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (snap() !== RESET_SNAP) begin
      failures++;
      $display("FAIL reset_idle: got %h expected %h", snap(), RESET_SNAP);
    end
  endtask

  task automatic test_single_write_read();
    do_txn(0, 1'b1, 5'h03, 8'hA5, 1'b0, "wr03");
    checks++;
    if (mem[3] !== 8'hA5) begin
      failures++;
      $display("FAIL wr03_ram: RAM[3]=%h expected a5", mem[3]);
    end
    do_txn(0, 1'b0, 5'h03, 8'h00, 1'b0, "rd03");
    checks++;
    if (RD_DATA !== 8'hA5) begin
      failures++;
      $display("FAIL rd03_hold: RD_DATA=%h expected a5", RD_DATA);
    end
  endtask

  task automatic test_reset_mid();
    set_port(0, 1'b1, 5'h07, 8'h5A);
    REQ[0] = 1'b1;
    tick();
    tick();
    checks++;
    if (RAM_WD_EN !== 1'b1) begin
      failures++;
      $display("FAIL midrst_access: WD_EN=%b expected 1", RAM_WD_EN);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (snap() !== RESET_SNAP) begin
      failures++;
      $display("FAIL midrst_values: got %h expected %h", snap(), RESET_SNAP);
    end
    REQ = 2'b00;
    repeat (3) tick();
    checks++;
    if (mem[7] !== exp_mem[7]) begin
      failures++;
      $display("FAIL midrst_ram: RAM[7]=%h expected %h", mem[7], exp_mem[7]);
    end
    RST = 1'b1;
    tick();
  endtask

  task automatic test_simultaneous();
    int a0;
    int a1;
    a0 = -1;
    a1 = -1;
    set_port(0, 1'b1, 5'h0A, 8'h11);
    set_port(1, 1'b1, 5'h0B, 8'h22);
    push_txn(0, 1'b1, 5'h0A, 8'h11);
    push_txn(1, 1'b1, 5'h0B, 8'h22);
    REQ = 2'b11;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) begin
        checks++;
        if (GNT !== 2'b01) begin
          failures++;
          $display("FAIL sim_first: GNT=%b expected 01", GNT);
        end
      end
      if (n == 4) begin
        checks++;
        if (GNT !== 2'b10 || BUSY !== 1'b1) begin
          failures++;
          $display("FAIL sim_b2b: GNT=%b BUSY=%b expected 10 and 1", GNT, BUSY);
        end
      end
      if (ACK[0]) begin
        a0 = n;
        REQ[0] = 1'b0;
      end
      if (ACK[1]) begin
        a1 = n;
        REQ[1] = 1'b0;
      end
    end
    checks++;
    if (a0 != 3 || a1 != 6 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL sim_timing: ack0 at %0d ack1 at %0d BUSY=%b expected 3, 6, 0", a0, a1, BUSY);
    end
    checks++;
    if (mem[10] !== 8'h11 || mem[11] !== 8'h22) begin
      failures++;
      $display("FAIL sim_ram: RAM[a]=%h RAM[b]=%h expected 11 22", mem[10], mem[11]);
    end
  endtask

  task automatic test_fairness();
    int order[$];
    int j0;
    int j1;
    int n;
    for (int j = 0; j < 3; j++) begin
      push_txn(0, 1'b1, 5'(16 + j), 8'(64 + j));
      push_txn(1, 1'b0, 5'(16 + j), 8'h00);
    end
    j0 = 0;
    j1 = 0;
    n  = 0;
    set_port(0, 1'b1, 5'h10, 8'h40);
    set_port(1, 1'b0, 5'h10, 8'h00);
    REQ = 2'b11;
    while (order.size() < 6 && n < 40) begin
      tick();
      n++;
      if (ACK == 2'b01) begin
        order.push_back(0);
        j0++;
        if (j0 < 3) set_port(0, 1'b1, 5'(16 + j0), 8'(64 + j0));
        else REQ[0] = 1'b0;
      end else if (ACK == 2'b10) begin
        order.push_back(1);
        j1++;
        if (j1 < 3) set_port(1, 1'b0, 5'(16 + j1), 8'h00);
        else REQ[1] = 1'b0;
      end
    end
    REQ = 2'b00;
    checks++;
    if (order.size() != 6 || n != 18) begin
      failures++;
      $display("FAIL fair_count: %0d acks in %0d edges, expected 6 in 18", order.size(), n);
    end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] != k % 2) begin
        failures++;
        $display("FAIL fair_order[%0d]: requester %0d expected %0d", k, order[k], k % 2);
      end
    end
    tick();
    checks++;
    if (BUSY !== 1'b0) begin
      failures++;
      $display("FAIL fair_idle: BUSY=%b expected 0", BUSY);
    end
  endtask

  task automatic test_early_drop();
    do_txn(1, 1'b1, 5'h1F, 8'h3C, 1'b1, "early");
    checks++;
    if (mem[31] !== 8'h3C) begin
      failures++;
      $display("FAIL early_ram: RAM[31]=%h expected 3c", mem[31]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write_read();
    test_reset_mid();
    test_simultaneous();
    test_fairness();
    test_early_drop();
    repeat (2) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d transactions never acknowledged", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
